// File: rtl/iic_eeprom_slave.sv
// I2C responder emulating a 24C32/64-style EEPROM: 2-byte word address, page writes,
// current-address and sequential reads. SDA is driven open-drain via sda_oe.
module iic_eeprom_slave #(
  parameter logic [6:0]  DEV_ADDR = 7'b1010000,
  parameter int unsigned MEM_AW   = 8,
  parameter int unsigned PAGE_AW  = 5
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic scl,
  input  logic sda_in,
  output logic sda_oe,
  output logic bus_active,
  output logic wr_pulse,
  output logic nack_sent
);

  typedef enum logic [3:0] {
    StIdle, StDevAddr, StAckDev, StAddrHi, StAckHi, StAddrLo, StAckLo,
    StWrData, StAckWr, StRdData, StRdAck, StRdLoad, StIgnore
  } state_e;

  localparam logic [MEM_AW-1:0] PageMask = MEM_AW'((1 << PAGE_AW) - 1);

  state_e              state_q, state_d;
  logic [1:0]          scl_sync_q, sda_sync_q;
  logic                scl_hist_q, sda_hist_q;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [6:0]          shift_q, shift_d;
  logic [7:0]          addr_hi_q, addr_hi_d;
  logic [MEM_AW-1:0]   addr_ptr_q, addr_ptr_d;
  logic [7:0]          rd_q, rd_d;
  logic                rw_q, rw_d;
  logic                sda_oe_q, sda_oe_d;
  logic                bus_active_q, bus_active_d;
  logic                wr_pulse_q, wr_pulse_d;
  logic                nack_q, nack_d;
  logic [7:0]          mem_q [2**MEM_AW];

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic shifting, ack_state, byte_done, ack_release, mem_we, load_rd;
  logic [7:0] byte_in, rd_byte;
  logic [MEM_AW-1:0] ptr_page_inc;

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s & scl_hist_q;
  // SCL must be stable high across the sample; a simultaneous change counts as data.
  assign start_det = scl_s & scl_hist_q & ~sda_s & sda_hist_q;
  assign stop_det  = scl_s & scl_hist_q & sda_s & ~sda_hist_q;

  assign byte_in      = {shift_q, sda_s};
  assign rd_byte      = mem_q[addr_ptr_q];
  assign ptr_page_inc = ((addr_ptr_q + 1'b1) & PageMask) | (addr_ptr_q & ~PageMask);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scl_sync_q   <= 2'b11;
      sda_sync_q   <= 2'b11;
      scl_hist_q   <= 1'b1;
      sda_hist_q   <= 1'b1;
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      addr_hi_q    <= '0;
      addr_ptr_q   <= '0;
      rd_q         <= '0;
      rw_q         <= 1'b0;
      sda_oe_q     <= 1'b0;
      bus_active_q <= 1'b0;
      wr_pulse_q   <= 1'b0;
      nack_q       <= 1'b0;
    end else begin
      scl_sync_q   <= {scl_sync_q[0], scl};
      sda_sync_q   <= {sda_sync_q[0], sda_in};
      scl_hist_q   <= scl_s;
      sda_hist_q   <= sda_s;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      addr_hi_q    <= addr_hi_d;
      addr_ptr_q   <= addr_ptr_d;
      rd_q         <= rd_d;
      rw_q         <= rw_d;
      sda_oe_q     <= sda_oe_d;
      bus_active_q <= bus_active_d;
      wr_pulse_q   <= wr_pulse_d;
      nack_q       <= nack_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge sys_clk) begin
    if (mem_we) begin
      mem_q[addr_ptr_q] <= byte_in;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    addr_hi_d    = addr_hi_q;
    addr_ptr_d   = addr_ptr_q;
    rd_d         = rd_q;
    rw_d         = rw_q;
    sda_oe_d     = sda_oe_q;
    bus_active_d = bus_active_q;
    wr_pulse_d   = 1'b0;
    nack_d       = 1'b0;
    mem_we       = 1'b0;
    load_rd      = 1'b0;
    shifting     = state_q inside {StDevAddr, StAddrHi, StAddrLo, StWrData};
    ack_state    = state_q inside {StAckDev, StAckHi, StAckLo, StAckWr};
    byte_done    = shifting & scl_rise & (bit_cnt_q == 4'd7);
    // First fall in an ACK state asserts the ACK, the second one ends it.
    ack_release  = ack_state & scl_fall & sda_oe_q;

    if (start_det) begin
      state_d      = StDevAddr;
      bit_cnt_d    = '0;
      sda_oe_d     = 1'b0;
      bus_active_d = 1'b1;
    end else if (stop_det) begin
      state_d      = StIdle;
      bit_cnt_d    = '0;
      sda_oe_d     = 1'b0;
      bus_active_d = 1'b0;
    end else begin
      if (shifting && scl_rise) begin
        shift_d   = byte_in[6:0];
        bit_cnt_d = byte_done ? 4'd0 : bit_cnt_q + 4'd1;
      end
      if (ack_state && scl_fall) begin
        sda_oe_d = ~sda_oe_q;
      end
      unique case (state_q)
        StDevAddr: begin
          if (byte_done) begin
            if (byte_in[7:1] == DEV_ADDR) begin
              rw_d    = byte_in[0];
              state_d = StAckDev;
            end else begin
              nack_d  = 1'b1;
              state_d = StIgnore;
            end
          end
        end
        StAddrHi: begin
          if (byte_done) begin
            addr_hi_d = byte_in;
            state_d   = StAckHi;
          end
        end
        StAddrLo: begin
          if (byte_done) begin
            addr_ptr_d = MEM_AW'({addr_hi_q, byte_in});
            state_d    = StAckLo;
          end
        end
        StWrData: begin
          if (byte_done) begin
            mem_we     = 1'b1;
            wr_pulse_d = 1'b1;
            addr_ptr_d = ptr_page_inc;
            state_d    = StAckWr;
          end
        end
        StAckDev: begin
          if (ack_release) begin
            if (rw_q) begin
              load_rd = 1'b1;
            end else begin
              state_d = StAddrHi;
            end
          end
        end
        StAckHi: if (ack_release) state_d = StAddrLo;
        StAckLo: if (ack_release) state_d = StWrData;
        StAckWr: if (ack_release) state_d = StWrData;
        StRdData: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = StRdAck;
            end else begin
              sda_oe_d = ~rd_q[7];
              rd_d     = {rd_q[6:0], 1'b0};
            end
          end
        end
        StRdAck: begin
          if (scl_rise) begin
            if (!sda_s) begin
              addr_ptr_d = addr_ptr_q + 1'b1;
              state_d    = StRdLoad;
            end else begin
              state_d = StIgnore;
            end
          end
        end
        StRdLoad: if (scl_fall) load_rd = 1'b1;
        StIdle, StIgnore: sda_oe_d = 1'b0;
        default: state_d = StIdle;
      endcase
      // Fetch the byte and drive its MSB on the fall that opens the first data bit.
      if (load_rd) begin
        rd_d      = {rd_byte[6:0], 1'b0};
        sda_oe_d  = ~rd_byte[7];
        bit_cnt_d = '0;
        state_d   = StRdData;
      end
    end
  end

  always_comb begin
    sda_oe     = sda_oe_q;
    bus_active = bus_active_q;
    wr_pulse   = wr_pulse_q;
    nack_sent  = nack_q;
  end

endmodule

// File: tb/tb_iic_eeprom_slave.sv
// Directed bench for iic_eeprom_slave: bit-banged I2C master on an open-drain bus model.
module tb_iic_eeprom_slave;

  localparam int unsigned Q = 50;  // quarter SCL period; SCL = 20 sys_clk cycles

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl = 1'b1;
  logic m_sda = 1'b1;
  logic sda_oe, bus_active, wr_pulse, nack_sent;
  logic sda_bus;

  int unsigned n_checks = 0;
  int unsigned n_errs = 0;
  int unsigned wr_cnt = 0;
  int unsigned nack_cnt = 0;
  int unsigned exp_wr = 0;

  assign sda_bus = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  iic_eeprom_slave dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .scl       (scl),
    .sda_in    (sda_bus),
    .sda_oe    (sda_oe),
    .bus_active(bus_active),
    .wr_pulse  (wr_pulse),
    .nack_sent (nack_sent)
  );

  always @(posedge clk) begin
    if (wr_pulse) wr_cnt <= wr_cnt + 1;
    if (nack_sent) nack_cnt <= nack_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; #Q;
    scl = 1'b1;   #Q;
    m_sda = 1'b0; #Q;
    scl = 1'b0;   #Q;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #Q;
    scl = 1'b1;   #Q;
    m_sda = 1'b1; #Q;
  endtask

  task automatic i2c_bit(input logic b, output logic s);
    m_sda = b; #Q;
    scl = 1'b1; #Q;
    s = sda_bus; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic i2c_wbyte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) i2c_bit(d[i], s);
    i2c_bit(1'b1, ack);
  endtask

  task automatic i2c_rbyte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, s);
      d[i] = s;
    end
    i2c_bit(mack, s);
  endtask

  task automatic wr_acked(input string tag, input logic [7:0] d);
    logic ack;
    i2c_wbyte(d, ack);
    check(tag, {31'd0, ack}, 32'd0);
  endtask

  task automatic rd_expect(input string tag, input logic mack, input logic [7:0] exp);
    logic [7:0] d;
    i2c_rbyte(mack, d);
    check(tag, {24'd0, d}, {24'd0, exp});
  endtask

  // Start + write header + ignored high byte + low byte; leaves the bus mid-write.
  task automatic set_ptr(input logic [7:0] lo);
    i2c_start();
    wr_acked("hdr_wr", 8'hA0);
    wr_acked("addr_hi", 8'h12);
    wr_acked("addr_lo", lo);
  endtask

  initial begin
    logic ack, s;
    #22;
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_bus_active", {31'd0, bus_active}, 32'd0);
    check("rst_wr_pulse", {31'd0, wr_pulse}, 32'd0);
    check("rst_nack_sent", {31'd0, nack_sent}, 32'd0);
    rst_n = 1'b1;
    #Q;

    // Page write A0..A3 from 0x20.
    i2c_start();
    check("t1_bus_active", {31'd0, bus_active}, 32'd1);
    wr_acked("t1_hdr", 8'hA0);
    wr_acked("t1_ahi", 8'h12);
    wr_acked("t1_alo", 8'h20);
    for (int i = 0; i < 4; i++) wr_acked("t1_data", 8'hA0 + 8'(i));
    i2c_stop();
    exp_wr += 4;
    #Q;
    check("t1_wr_cnt", wr_cnt, exp_wr);
    check("t1_bus_idle", {31'd0, bus_active}, 32'd0);

    // Random read of 0x20..0x23.
    set_ptr(8'h20);
    i2c_start();
    wr_acked("t2_hdr_rd", 8'hA1);
    rd_expect("t2_rd0", 1'b0, 8'hA0);
    rd_expect("t2_rd1", 1'b0, 8'hA1);
    rd_expect("t2_rd2", 1'b0, 8'hA2);
    rd_expect("t2_rd3", 1'b1, 8'hA3);
    check("t2_released", {31'd0, sda_oe}, 32'd0);
    i2c_stop();

    // Page wrap at offset 0x3F; 0x40 must stay at its own value.
    set_ptr(8'h40);
    wr_acked("t3_w40", 8'h77);
    i2c_stop();
    set_ptr(8'h3F);
    wr_acked("t3_w11", 8'h11);
    wr_acked("t3_w22", 8'h22);
    wr_acked("t3_w33", 8'h33);
    i2c_stop();
    exp_wr += 4;
    #Q;
    check("t3_wr_cnt", wr_cnt, exp_wr);
    set_ptr(8'h3F);
    i2c_start();
    wr_acked("t3_hdr_rd", 8'hA1);
    rd_expect("t3_m3f", 1'b0, 8'h11);
    rd_expect("t3_m40", 1'b1, 8'h77);
    set_ptr(8'h20);
    i2c_start();
    wr_acked("t3_hdr_rd2", 8'hA1);
    rd_expect("t3_m20", 1'b0, 8'h22);
    rd_expect("t3_m21", 1'b1, 8'h33);
    i2c_stop();

    // Wrong device address.
    i2c_start();
    i2c_wbyte(8'hA2, ack);
    check("t4_nack_bit", {31'd0, ack}, 32'd1);
    i2c_stop();
    #Q;
    check("t4_nack_cnt", nack_cnt, 32'd1);
    check("t4_no_write", wr_cnt, exp_wr);
    i2c_start();
    wr_acked("t4_hdr_ok", 8'hA0);
    i2c_stop();
    #Q;
    check("t4_nack_cnt2", nack_cnt, 32'd1);

    // Sequential read across the top of the array.
    set_ptr(8'hFF);
    wr_acked("t5_wff", 8'h5A);
    i2c_stop();
    set_ptr(8'h00);
    wr_acked("t5_w00", 8'hC3);
    i2c_stop();
    exp_wr += 2;
    set_ptr(8'hFF);
    i2c_start();
    wr_acked("t5_hdr_rd", 8'hA1);
    rd_expect("t5_mff", 1'b0, 8'h5A);
    rd_expect("t5_m00", 1'b1, 8'hC3);
    i2c_stop();

    // STOP after 5 data bits must not write.
    set_ptr(8'h40);
    for (int i = 0; i < 5; i++) i2c_bit(1'b0, s);
    i2c_stop();
    #Q;
    check("t6_no_write", wr_cnt, exp_wr);
    check("t6_bus_idle", {31'd0, bus_active}, 32'd0);
    set_ptr(8'h40);
    i2c_start();
    wr_acked("t6_hdr_rd", 8'hA1);
    rd_expect("t6_m40", 1'b1, 8'h77);
    i2c_stop();

    // Reset while the slave drives a 0 (MSB of 0x33).
    set_ptr(8'h21);
    i2c_start();
    wr_acked("t6_hdr_rd2", 8'hA1);
    #Q;
    check("t6_driving", {31'd0, sda_oe}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("t6_rst_bus", {31'd0, bus_active}, 32'd0);
    #Q;
    rst_n = 1'b1;
    m_sda = 1'b1;
    scl = 1'b1;
    #(4 * Q);
    check("t6_rst_no_write", wr_cnt, exp_wr);
    set_ptr(8'h21);
    i2c_start();
    wr_acked("t6_hdr_rd3", 8'hA1);
    rd_expect("t6_m21", 1'b1, 8'h33);
    i2c_stop();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
